// File: rtl/full_logic_traffic_checker.sv
// full_logic_traffic_checker
//
// Drives configuration and write traffic into two full-logic datapath
// instances ("a" = behavioural, "b" = synthesized), drains their per-channel
// output FIFOs and compares the two instances cycle by cycle. Reports a
// saturating mismatch count, the cycle of the first mismatch and a verdict.
//
// Ports
//   clk                      system clock, rising edge
//   reset                    asynchronous, active-low
//   start                    one-cycle pulse, starts a run from IDLE or DONE
//   mode                     0 = incrementing pattern, 1 = LFSR pattern
//   num_words                words to write per run (0 skips WRITE)
//   cfg_umbral_MFs/VCs/Ds    thresholds captured at start
//   pause                    back-pressure, stalls WRITE
//   wr_enable, data_in       write strobe and data to both instances
//   init                     instance init, low during CONFIG
//   umbral_MFs/VCs/Ds        registered thresholds
//   pop                      per-channel pop to both instances
//   data_out_a/b, empty_a/b  channel outputs and FIFO empty flags
//   error_a/b, idle_a/b      instance state flags
//   busy, done, pass         run status; pass valid while done
//   mismatch_cnt             saturating count of mismatching cycles
//   first_mismatch           cycle of first mismatch, all-ones if none
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start, outputs quiet
// CONFIG | init held low for CFG_CYCLES cycles, thresholds applied
// WRITE  | one word per non-paused cycle until num_words issued
// DRAIN  | pop every non-empty channel until empty or timeout
// DONE   | verdict valid, waiting for start or reset

module full_logic_traffic_checker #(
    parameter int DATA_WIDTH    = 6,
    parameter int NUM_CH        = 2,
    parameter int CNT_WIDTH     = 8,
    parameter int DRAIN_TIMEOUT = 32,
    parameter int CFG_CYCLES    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         mode,
    input  logic [CNT_WIDTH-1:0]         num_words,
    input  logic [3:0]                   cfg_umbral_MFs,
    input  logic [3:0]                   cfg_umbral_VCs,
    input  logic [3:0]                   cfg_umbral_Ds,
    input  logic                         pause,
    output logic                         wr_enable,
    output logic [DATA_WIDTH-1:0]        data_in,
    output logic                         init,
    output logic [3:0]                   umbral_MFs,
    output logic [3:0]                   umbral_VCs,
    output logic [3:0]                   umbral_Ds,
    output logic [NUM_CH-1:0]            pop,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_out_a,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_out_b,
    input  logic [NUM_CH-1:0]            empty_a,
    input  logic [NUM_CH-1:0]            empty_b,
    input  logic                         error_a,
    input  logic                         error_b,
    input  logic                         idle_a,
    input  logic                         idle_b,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [CNT_WIDTH-1:0]         mismatch_cnt,
    output logic [CNT_WIDTH-1:0]         first_mismatch
);

    localparam int CFG_W = (CFG_CYCLES > 1) ? $clog2(CFG_CYCLES + 1) : 1;
    localparam int DRN_W = $clog2(DRAIN_TIMEOUT + 1);

    // Fibonacci tap masks (bit n-1 = x^n term). The MSB is always tapped, so
    // a non-zero register can never shift into the all-zero state.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            2:       lfsr_taps = 32'h0000_0003;
            3:       lfsr_taps = 32'h0000_0006;
            4:       lfsr_taps = 32'h0000_000C;
            5:       lfsr_taps = 32'h0000_0014;
            6:       lfsr_taps = 32'h0000_0030;
            7:       lfsr_taps = 32'h0000_0060;
            8:       lfsr_taps = 32'h0000_00B8;
            9:       lfsr_taps = 32'h0000_0110;
            10:      lfsr_taps = 32'h0000_0240;
            11:      lfsr_taps = 32'h0000_0500;
            12:      lfsr_taps = 32'h0000_0E08;
            13:      lfsr_taps = 32'h0000_1C80;
            14:      lfsr_taps = 32'h0000_3802;
            15:      lfsr_taps = 32'h0000_6000;
            16:      lfsr_taps = 32'h0000_D008;
            default: lfsr_taps = (32'h1 << (width - 1)) | (32'h1 << (width - 2));
        endcase
    endfunction

    localparam logic [DATA_WIDTH-1:0] LFSR_TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] LFSR_SEED = DATA_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_WIDTH-1:0]  nw_r;
    logic                  mode_r;
    logic [CNT_WIDTH-1:0]  words_sent;
    logic [DATA_WIDTH-1:0] lfsr;
    logic [CFG_W-1:0]      cfg_cnt;
    logic [DRN_W-1:0]      drain_cnt;
    logic                  empty_seen;
    logic [CNT_WIDTH-1:0]  cycle_cnt;
    logic                  found;
    logic                  timeout_r;

    logic                  start_run;
    logic                  write_now;
    logic                  last_word;
    logic                  cfg_last;
    logic                  all_empty;
    logic                  drain_exit_empty;
    logic                  drain_exit_timeout;
    logic                  check_active;
    logic                  data_diff;
    logic                  mismatch_now;
    logic [DATA_WIDTH-1:0] pattern;
    logic [DATA_WIDTH-1:0] lfsr_next;

    assign start_run  = start && ((state == S_IDLE) || (state == S_DONE));
    assign write_now  = (state == S_WRITE) && !pause;
    assign last_word  = write_now && ((words_sent + CNT_WIDTH'(1)) == nw_r);
    assign cfg_last   = (state == S_CONFIG) && (cfg_cnt == CFG_W'(CFG_CYCLES - 1));
    assign all_empty  = &empty_a;

    // Two consecutive all-empty cycles: the current one plus the one remembered.
    assign drain_exit_empty   = (state == S_DRAIN) && all_empty && empty_seen;
    assign drain_exit_timeout = (state == S_DRAIN) && !drain_exit_empty &&
                                (drain_cnt == DRN_W'(DRAIN_TIMEOUT - 1));

    assign lfsr_next = {lfsr[DATA_WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
    assign pattern   = mode_r ? lfsr : DATA_WIDTH'(words_sent);

    assign check_active = (state == S_CONFIG) || (state == S_WRITE) || (state == S_DRAIN);

    // Data of an empty channel is stale, so only live channels are compared.
    always_comb begin
        data_diff = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!empty_a[k] &&
                (data_out_a[k*DATA_WIDTH +: DATA_WIDTH] != data_out_b[k*DATA_WIDTH +: DATA_WIDTH])) begin
                data_diff = 1'b1;
            end
        end
    end

    assign mismatch_now = (empty_a != empty_b) || (error_a != error_b) ||
                          (idle_a != idle_b) || data_diff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_enable  = 1'b0;
        data_in    = '0;
        init       = 1'b0;
        pop        = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CONFIG;
                end
            end
            S_CONFIG: begin
                busy = 1'b1;
                if (cfg_last) begin
                    state_next = (nw_r == '0) ? S_DRAIN : S_WRITE;
                end
            end
            S_WRITE: begin
                busy      = 1'b1;
                init      = 1'b1;
                wr_enable = !pause;
                data_in   = pattern;
                if (last_word) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                init = 1'b1;
                pop  = ~empty_a;
                if (drain_exit_empty || drain_exit_timeout) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                init = 1'b1;
                done = 1'b1;
                if (start) begin
                    state_next = S_CONFIG;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign pass = (state == S_DONE) && (mismatch_cnt == '0) && !timeout_r &&
                  !error_a && !error_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            umbral_MFs     <= '0;
            umbral_VCs     <= '0;
            umbral_Ds      <= '0;
            nw_r           <= '0;
            mode_r         <= 1'b0;
            words_sent     <= '0;
            lfsr           <= LFSR_SEED;
            cfg_cnt        <= '0;
            drain_cnt      <= '0;
            empty_seen     <= 1'b0;
            cycle_cnt      <= '0;
            mismatch_cnt   <= '0;
            first_mismatch <= '1;
            found          <= 1'b0;
            timeout_r      <= 1'b0;
        end else if (start_run) begin
            umbral_MFs     <= cfg_umbral_MFs;
            umbral_VCs     <= cfg_umbral_VCs;
            umbral_Ds      <= cfg_umbral_Ds;
            nw_r           <= num_words;
            mode_r         <= mode;
            words_sent     <= '0;
            lfsr           <= LFSR_SEED;
            cfg_cnt        <= '0;
            drain_cnt      <= '0;
            empty_seen     <= 1'b0;
            cycle_cnt      <= '0;
            mismatch_cnt   <= '0;
            first_mismatch <= '1;
            found          <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            if (state == S_CONFIG) begin
                cfg_cnt <= cfg_cnt + CFG_W'(1);
            end
            if (write_now) begin
                words_sent <= words_sent + CNT_WIDTH'(1);
                lfsr       <= lfsr_next;
            end
            if (state == S_DRAIN) begin
                drain_cnt  <= drain_cnt + DRN_W'(1);
                empty_seen <= all_empty;
                if (drain_exit_timeout) begin
                    timeout_r <= 1'b1;
                end
            end
            if (check_active) begin
                if (cycle_cnt != '1) begin
                    cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
                end
                if (mismatch_now) begin
                    if (mismatch_cnt != '1) begin
                        mismatch_cnt <= mismatch_cnt + CNT_WIDTH'(1);
                    end
                    if (!found) begin
                        found          <= 1'b1;
                        first_mismatch <= cycle_cnt;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_full_logic_traffic_checker.sv
// Bench for full_logic_traffic_checker. Two identical FIFO-based stand-ins
// play the "a" and "b" instances; faults are injected on the "b" data path
// or the "a" empty flag to exercise the checker.

module tb_full_logic_traffic_checker;

    localparam int DW  = 6;
    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int FD  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              mode;
    logic [CW-1:0]     num_words;
    logic [3:0]        cfg_mf, cfg_vc, cfg_d;
    logic              pause;
    logic              wr_enable;
    logic [DW-1:0]     data_in;
    logic              init;
    logic [3:0]        umbral_MFs, umbral_VCs, umbral_Ds;
    logic [NCH-1:0]    pop;
    logic [NCH*DW-1:0] data_out_a, data_out_b;
    logic [NCH-1:0]    empty_a, empty_b, empty_m;
    logic              error_a, error_b, idle_a, idle_b;
    logic              busy, done, pass;
    logic [CW-1:0]     mismatch_cnt, first_mismatch;

    logic              corrupt;
    logic              stuck;

    full_logic_traffic_checker #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .CNT_WIDTH(CW),
        .DRAIN_TIMEOUT(32), .CFG_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .num_words(num_words),
        .cfg_umbral_MFs(cfg_mf), .cfg_umbral_VCs(cfg_vc), .cfg_umbral_Ds(cfg_d),
        .pause(pause), .wr_enable(wr_enable), .data_in(data_in), .init(init),
        .umbral_MFs(umbral_MFs), .umbral_VCs(umbral_VCs), .umbral_Ds(umbral_Ds),
        .pop(pop), .data_out_a(data_out_a), .data_out_b(data_out_b),
        .empty_a(empty_a), .empty_b(empty_b),
        .error_a(error_a), .error_b(error_b), .idle_a(idle_a), .idle_b(idle_b),
        .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .first_mismatch(first_mismatch)
    );

    always #5 clk = ~clk;

    // Stand-in datapath: words routed to channel data[0], depth FD, overflow dropped.
    logic [DW-1:0] fmem [NCH][FD];
    int            fcnt [NCH];
    int            frd  [NCH];

    always @(posedge clk) begin
        if (!reset || !init) begin
            for (int k = 0; k < NCH; k++) begin
                fcnt[k] <= 0;
                frd[k]  <= 0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (pop[k] && fcnt[k] != 0) begin
                    frd[k]  <= (frd[k] + 1) % FD;
                    fcnt[k] <= fcnt[k] - 1;
                end
            end
            if (wr_enable) begin
                int ch;
                ch = int'(data_in[0]);
                if (fcnt[ch] < FD) begin
                    fmem[ch][(frd[ch] + fcnt[ch]) % FD] <= data_in;
                    fcnt[ch] <= fcnt[ch] + 1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            empty_m[k] = (fcnt[k] == 0);
            data_out_a[k*DW +: DW] = fmem[k][frd[k]];
        end
        data_out_b = data_out_a;
        if (corrupt) data_out_b[DW +: DW] = ~data_out_a[DW +: DW];
        empty_b = empty_m;
        empty_a = empty_m;
        if (stuck) empty_a[0] = 1'b0;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-run recorders
    logic [DW-1:0] wr_data [256];
    int wr_n, first_wr, last_wr, cfg_lows, pop0_n, hold_bad;
    bit done_seen;

    task automatic do_run(input bit md, input int nw, input int p_from, input int p_len,
                          input int c_from, input int c_len, input int restart_at);
        mode      = md;
        num_words = CW'(nw);
        wr_n = 0; first_wr = -1; last_wr = -1; cfg_lows = 0; pop0_n = 0; hold_bad = 0;
        done_seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            pause   = (cyc >= p_from) && (cyc < p_from + p_len);
            corrupt = (cyc >= c_from) && (cyc < c_from + c_len);
            start   = (cyc == restart_at);
            @(negedge clk);
            if (wr_enable) begin
                if (pause) hold_bad++;
                if (wr_n < 256) wr_data[wr_n] = data_in;
                if (wr_n == 0) first_wr = cyc;
                last_wr = cyc;
                wr_n++;
            end else if (pause && !md && busy && init && wr_n > 0 && wr_n < nw) begin
                if (data_in != DW'(wr_n)) hold_bad++;
            end
            if (busy && !init) cfg_lows++;
            if (pop[0]) pop0_n++;
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        pause = 1'b0; corrupt = 1'b0; start = 1'b0;
        check_val("run_done", done_seen, 1);
    endtask

    int bad;

    initial begin
        reset = 1'b0; start = 1'b0; mode = 1'b0; num_words = '0; pause = 1'b0;
        cfg_mf = 4'd1; cfg_vc = 4'd1; cfg_d = 4'd2;
        error_a = 1'b0; error_b = 1'b0; idle_a = 1'b0; idle_b = 1'b0;
        corrupt = 1'b0; stuck = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_pass", pass, 0);
        check_val("rst_wr_enable", wr_enable, 0);
        check_val("rst_init", init, 0);
        check_val("rst_pop", pop, 0);
        check_val("rst_data_in", data_in, 0);
        check_val("rst_umbral_MFs", umbral_MFs, 0);
        check_val("rst_mismatch_cnt", mismatch_cnt, 0);
        check_val("rst_first_mismatch", first_mismatch, 255);
        reset = 1'b1;
        @(negedge clk);

        // Clean incrementing run
        do_run(1'b0, 10, -1, 0, -1, 0, -1);
        check_val("r1_writes", wr_n, 10);
        bad = 0;
        for (int i = 0; i < 10; i++) if (wr_data[i] != DW'(i)) bad++;
        check_val("r1_data_bad", bad, 0);
        check_val("r1_first_wr_cycle", first_wr, 2);
        check_val("r1_wr_span", last_wr - first_wr, 9);
        check_val("r1_cfg_low_cycles", cfg_lows, 2);
        check_val("r1_pass", pass, 1);
        check_val("r1_busy", busy, 0);
        check_val("r1_mismatch_cnt", mismatch_cnt, 0);
        check_val("r1_first_mismatch", first_mismatch, 255);
        check_val("r1_umbral_MFs", umbral_MFs, 1);
        check_val("r1_umbral_VCs", umbral_VCs, 1);
        check_val("r1_umbral_Ds", umbral_Ds, 2);

        // Re-run from DONE with a 3-cycle pause and a stray start mid-WRITE
        cfg_mf = 4'd3; cfg_vc = 4'd4; cfg_d = 4'd5;
        do_run(1'b0, 10, 5, 3, -1, 0, 9);
        check_val("r2_writes", wr_n, 10);
        bad = 0;
        for (int i = 0; i < 10; i++) if (wr_data[i] != DW'(i)) bad++;
        check_val("r2_data_bad", bad, 0);
        check_val("r2_wr_span", last_wr - first_wr, 12);
        check_val("r2_pause_hold_bad", hold_bad, 0);
        check_val("r2_pass", pass, 1);
        check_val("r2_umbral_Ds", umbral_Ds, 5);

        // Channel 1 of b corrupted in cycles 7 and 8
        do_run(1'b0, 10, -1, 0, 7, 2, -1);
        check_val("r3_mismatch_cnt", mismatch_cnt, 2);
        check_val("r3_first_mismatch", first_mismatch, 7);
        check_val("r3_pass", pass, 0);

        // num_words = 0 skips WRITE; results cleared from previous run
        do_run(1'b0, 0, -1, 0, -1, 0, -1);
        check_val("r4_writes", wr_n, 0);
        check_val("r4_mismatch_cnt", mismatch_cnt, 0);
        check_val("r4_first_mismatch", first_mismatch, 255);
        check_val("r4_pass", pass, 1);

        // Both instances in error: no mismatch, but no pass either
        error_a = 1'b1; error_b = 1'b1;
        do_run(1'b0, 3, -1, 0, -1, 0, -1);
        check_val("r5_mismatch_cnt", mismatch_cnt, 0);
        check_val("r5_pass", pass, 0);
        error_a = 1'b0; error_b = 1'b0;

        // empty_a[0] stuck low: drain timeout
        stuck = 1'b1;
        do_run(1'b0, 4, -1, 0, -1, 0, -1);
        check_val("r6_drain_cycles", pop0_n, 32);
        check_val("r6_first_mismatch", first_mismatch, 0);
        check_val("r6_pass", pass, 0);
        stuck = 1'b0;

        // LFSR mode, 70 words
        do_run(1'b1, 70, -1, 0, -1, 0, -1);
        check_val("r7_writes", wr_n, 70);
        check_val("r7_first_word", wr_data[0], 1);
        bad = 0;
        for (int i = 0; i < 70; i++) if (wr_data[i] == '0) bad++;
        check_val("r7_zero_words", bad, 0);
        bad = 0;
        for (int i = 1; i < 70; i++) if (wr_data[i] == wr_data[i-1]) bad++;
        check_val("r7_stalled_words", bad, 0);
        check_val("r7_pass", pass, 1);

        // Reset in the middle of WRITE
        mode = 1'b0; num_words = CW'(10);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_val("r8_writing_before_reset", wr_enable, 1);
        #2 reset = 1'b0;
        #1;
        check_val("r8_wr_enable", wr_enable, 0);
        check_val("r8_busy", busy, 0);
        check_val("r8_init", init, 0);
        check_val("r8_data_in", data_in, 0);
        check_val("r8_umbral_MFs", umbral_MFs, 0);
        check_val("r8_first_mismatch", first_mismatch, 255);
        @(negedge clk);
        reset = 1'b1;
        do_run(1'b0, 10, -1, 0, -1, 0, -1);
        check_val("r8_rerun_writes", wr_n, 10);
        check_val("r8_rerun_cfg_low", cfg_lows, 2);
        check_val("r8_rerun_pass", pass, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
